alu_sequencer: RTL and testbench

Command-driven control stage directly upstream of the 8-bit combinational ALU (inputs a, b, op; outputs out, flag[3:0]). It accepts one command at a time over a valid/ready interface and reads operands from a small register file. It drives the ALU inputs from registered values, writes the result and flags back, and returns a response over a second valid/ready interface. It owns all sequencing, error detection and state; the ALU stays purely combinational.

---
 rtl/alu_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Control stage that sits directly in front of an external, purely
//   combinational DATA_W-bit ALU. It takes one command at a time, reads its
//   operands from a small register file, presents registered operands to the
//   ALU for one cycle, writes the result back and returns a response.
//
// Optional feature (compile-time macro STICKY_FLAGS_EN):
//   Defined   : sticky_flag accumulates the flags of every successful command
//               and is cleared by clr_sticky (the clear wins over an update).
//   Undefined : sticky_flag is tied to 0 and clr_sticky is ignored.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   cmd_*          command channel (valid/ready), op/dst/src_a/src_b/imm
//   alu_a/b/op     registered operands and opcode driven to the ALU
//   alu_out/flag   combinational result from the ALU
//   rsp_*          response channel (valid/ready), data/flag/err
//   dbg_addr/data  combinational read port into the register file
//   sticky_flag    accumulated flags; clr_sticky clears them
//
// Handshake rule (both channels): a transfer happens on a rising edge where
//   valid and ready are both 1. The producer holds valid and its payload
//   stable until that edge; ready may change freely.
//
// Opcodes: 0x0-0xB ALU ops (0x3 is divide), 0xC-0xE illegal, 0xF LOAD.
// rsp_flag layout: {borrow, mul_ovf, carry, zero}.
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_dst,
   input  logic [REG_AW-1:0] cmd_src_a,
   input  logic [REG_AW-1:0] cmd_src_b,
   input  logic              cmd_imm_en,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        alu_flag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_flag,
   output logic              rsp_err,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [3:0]        sticky_flag,
   input  logic              clr_sticky
);

   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_LOAD = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [DATA_W-1:0]   r_regs [NREGS];
   logic [3:0]          r_op;
   logic [REG_AW-1:0]   r_dst;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data;
   logic [3:0]          r_rsp_flag;
   logic                r_rsp_err;

   logic                w_err;
   logic                w_is_load;
   logic [DATA_W-1:0]   w_result;
   logic [3:0]          w_flag;

   // -----------------------------------------------------------------------
   // EXEC-cycle result selection. Divide by zero and the illegal opcodes are
   // rejected. The zero flag is always derived here from the value actually
   // written back, never taken from the ALU.
   // -----------------------------------------------------------------------
   always_comb begin
      w_err     = 1'b0;
      w_is_load = 1'b0;
      w_result  = alu_out;
      w_flag    = {alu_flag[3:1], (alu_out == '0)};
      if ((r_op == OP_DIV && r_b == '0) || (r_op >= 4'hC && r_op <= 4'hE)) begin
         w_err = 1'b1;
      end
      if (r_op == OP_LOAD) begin
         w_is_load = 1'b1;
         w_result  = r_b;
         w_flag    = {3'b000, (r_b == '0)};
      end
   end

   // -----------------------------------------------------------------------
   // FSM next state
   // -----------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_RESP;
         S_RESP:  if (rsp_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // State register, operand capture, writeback and response registers.
   // Operands are captured from the pre-edge register contents at accept.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_op        <= '0;
         r_dst       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_flag  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op  <= cmd_op;
                  r_dst <= cmd_dst;
                  r_a   <= r_regs[cmd_src_a];
                  r_b   <= cmd_imm_en ? cmd_imm : r_regs[cmd_src_b];
               end
            end
            S_EXEC: begin
               r_rsp_valid <= 1'b1;
               if (w_err) begin
                  r_rsp_data <= '0;
                  r_rsp_flag <= '0;
                  r_rsp_err  <= 1'b1;
               end else begin
                  r_regs[r_dst] <= w_result;
                  r_rsp_data    <= w_result;
                  r_rsp_flag    <= w_flag;
                  r_rsp_err     <= 1'b0;
               end
            end
            S_RESP: begin
               if (rsp_ready) r_rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef STICKY_FLAGS_EN
   logic [3:0] r_sticky;
   logic       w_unused;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sticky <= '0;
      end else if (clr_sticky) begin
         r_sticky <= '0;
      end else if (r_state == S_EXEC && !w_err) begin
         r_sticky <= r_sticky | w_flag;
      end
   end

   assign sticky_flag = r_sticky;
   assign w_unused    = alu_flag[0] ^ w_is_load;
`else
   logic w_unused;

   assign sticky_flag = 4'b0000;
   assign w_unused    = clr_sticky ^ alu_flag[0] ^ w_is_load;
`endif

   // -----------------------------------------------------------------------
   // Outputs. ALU inputs come straight from the operand registers, so they
   // are stable throughout EXEC and hold their last values elsewhere.
   // -----------------------------------------------------------------------
   assign cmd_ready = (r_state == S_IDLE);
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_op    = r_op;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_flag  = r_rsp_flag;
   assign rsp_err   = r_rsp_err;
   assign dbg_data  = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer with a small combinational ALU model attached.
// Directed commands push their hand-computed response ({err, flag, data})
// into exp_q; an independent monitor pops and compares on each response
// handshake and also checks the accept-to-response latency.
// ALU model opcodes: 0x0 ADD, 0x1 SUB, 0x2 MUL, 0x3 DIV, others AND.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int DATA_W = 8;
   localparam int REG_AW = 2;
   localparam int EW     = 1 + 4 + DATA_W;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_ILL  = 4'hD;
   localparam logic [3:0] OP_LOAD = 4'hF;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [3:0]        cmd_op = '0;
   logic [REG_AW-1:0] cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
   logic              cmd_imm_en = 1'b0;
   logic [DATA_W-1:0] cmd_imm = '0;
   logic [DATA_W-1:0] alu_a, alu_b, alu_out;
   logic [3:0]        alu_op, alu_flag;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_data;
   logic [3:0]        rsp_flag;
   logic              rsp_err;
   logic [REG_AW-1:0] dbg_addr = '0;
   logic [DATA_W-1:0] dbg_data;
   logic [3:0]        sticky_flag;
   logic              clr_sticky = 1'b0;

   alu_sequencer #(.DATA_W(DATA_W), .NREGS(4), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
      .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flag(alu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flag(rsp_flag), .rsp_err(rsp_err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .sticky_flag(sticky_flag), .clr_sticky(clr_sticky)
   );

   // ---------------- ALU model ----------------
   logic [DATA_W:0]     m_sum;
   logic [2*DATA_W-1:0] m_prod;
   always_comb begin
      m_sum    = '0;
      m_prod   = '0;
      alu_out  = '0;
      alu_flag = '0;
      case (alu_op)
         4'h0: begin
            m_sum       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out     = m_sum[DATA_W-1:0];
            alu_flag[1] = m_sum[DATA_W];
         end
         4'h1: begin
            alu_out     = alu_a - alu_b;
            alu_flag[3] = (alu_a < alu_b);
         end
         4'h2: begin
            m_prod      = alu_a * alu_b;
            alu_out     = m_prod[DATA_W-1:0];
            alu_flag[2] = |m_prod[2*DATA_W-1:DATA_W];
         end
         4'h3:    alu_out = (alu_b == '0) ? '1 : alu_a / alu_b;
         default: alu_out = alu_a & alu_b;
      endcase
      alu_flag[0] = (alu_out == '0);
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int  checks = 0;
   int  errors = 0;
   time t_accept = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares on every response handshake, checks latency on rise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid && !prev_valid)
            check("rsp_latency", 16'(($time - t_accept) / 5), 16'd3);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", {3'b0, rsp_err, rsp_flag, rsp_data}, 16'hFFFF);
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("rsp", {3'b0, rsp_err, rsp_flag, rsp_data}, {3'b0, e});
            end
         end
      end
      prev_valid = rst_n ? rsp_valid : 1'b0;
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ie, input logic [7:0] imm,
                       input logic push, input logic e_err, input logic [3:0] e_flag,
                       input logic [7:0] e_data);
      int n = 0;
      cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
      cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check("accept_timeout", 16'd0, 16'd1);
         cmd_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back({e_err, e_flag, e_data});
      @(posedge clk);
      t_accept = $time;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_timeout", 16'(exp_q.size()), 16'd0);
      @(negedge clk);
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      check(name, {8'h0, dbg_data}, {8'h0, exp});
   endtask

   task automatic pulse_clr();
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      #1;
      check("sticky_clr", {12'h0, sticky_flag}, 16'h0000);
   endtask

   logic [3:0] exp_sticky;

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", {15'h0, cmd_ready}, 16'h1);
      check("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);
      check("rst_rsp", {3'b0, rsp_err, rsp_flag, rsp_data}, 16'h0);
      check("rst_alu_in", {alu_op, 4'h0, alu_a}, 16'h0);
      check("rst_sticky", {12'h0, sticky_flag}, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // loads, add, sub, load zero
      send(OP_LOAD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 1'b1, 1'b0, 4'b0000, 8'h05);
      send(OP_LOAD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h03, 1'b1, 1'b0, 4'b0000, 8'h03);
      send(OP_ADD,  2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 8'h08);
      wait_idle();
      check_reg("dbg_r2_add", 2'd2, 8'h08);
      send(OP_SUB,  2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1000, 8'hFE);
      wait_idle();
      check_reg("dbg_r3_sub", 2'd3, 8'hFE);
      send(OP_LOAD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 1'b0, 4'b0001, 8'h00);
      wait_idle();
      check_reg("dbg_r3_load0", 2'd3, 8'h00);

      // errors: divide by zero and an illegal opcode
      send(OP_DIV,  2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 1'b1, 4'b0000, 8'h00);
      wait_idle();
      check_reg("dbg_r1_div0", 2'd1, 8'h03);
      send(OP_ILL,  2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000, 8'h00);
      wait_idle();
      check_reg("dbg_r0_illegal", 2'd0, 8'h05);

      // response backpressure
      rsp_ready = 1'b0;
      send(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h10, 1'b1, 1'b0, 4'b0000, 8'h15);
      cmd_op = OP_SUB; cmd_dst = 2'd3; cmd_src_a = 2'd3; cmd_src_b = 2'd1;
      cmd_imm_en = 1'b0; cmd_valid = 1'b1;
      for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("hold_rsp", {2'b0, rsp_valid, rsp_err, rsp_flag, rsp_data}, {2'b0, 1'b1, 1'b0, 4'b0000, 8'h15});
         check("hold_cmd_ready", {15'h0, cmd_ready}, 16'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      send(OP_SUB, 2'd3, 2'd3, 2'd1, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000, 8'h12);
      wait_idle();
      check_reg("dbg_r3_after_hold", 2'd3, 8'h12);

      // sticky flags
      pulse_clr();
      send(OP_SUB,  2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1000, 8'hFE);
      send(OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h80, 1'b1, 1'b0, 4'b0000, 8'h80);
      send(OP_ADD,  2'd2, 2'd2, 2'd0, 1'b1, 8'h80, 1'b1, 1'b0, 4'b0011, 8'h00);
      wait_idle();
`ifdef STICKY_FLAGS_EN
      exp_sticky = 4'b1011;
`else
      exp_sticky = 4'b0000;
`endif
      check("sticky_acc", {12'h0, sticky_flag}, {12'h0, exp_sticky});
      pulse_clr();

      // reset during EXEC drops the command
      send(OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h08, 1'b1, 1'b0, 4'b0000, 8'h08);
      wait_idle();
      check_reg("dbg_r2_pre_rst", 2'd2, 8'h08);
      send(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_cmd_ready", {15'h0, cmd_ready}, 16'h1);
      check("post_rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);
      for (int r = 0; r < 4; r++) check_reg("post_rst_reg", 2'(r), 8'h00);
      @(negedge clk);
      check("post_rst_idle", {14'h0, rsp_valid, cmd_ready}, 16'h1);

      // block still works after reset
      send(OP_LOAD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h2A, 1'b1, 1'b0, 4'b0000, 8'h2A);
      wait_idle();
      check_reg("dbg_r1_final", 2'd1, 8'h2A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
